// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS32 pipeline. Runs loads and stores on a
// req/ack data bus, steers byte/half lanes, sign/zero-extends load data,
// flags misaligned accesses and bounds each bus access with a timeout.

// Per-byte-lane store formatting: picks the store byte for this lane and
// decides whether this lane's byte enable is set.
module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        hlane,
  input  logic [31:0] wd,
  output logic [7:0]  byte_d,
  output logic        be
);
  // Byte replicates wd[7:0], half replicates wd[15:0], word passes straight.
  always_comb begin
    byte_d = wd[8*LANE +: 8];
    be     = 1'b1;
    case (size)
      2'b00: begin
        byte_d = wd[7:0];
        be     = (lane == 2'(LANE));
      end
      2'b01: begin
        byte_d = wd[8*(LANE%2) +: 8];
        be     = (hlane == 1'(LANE/2));
      end
      default: ;
    endcase
  end
endmodule

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit BIG_ENDIAN     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] ALUOutput_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  DstReg_in,
  input  logic [1:0]  WB_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUOutput_out,
  output logic [4:0]  DstReg_out,
  output logic [1:0]  WB_out,
  output logic        misalign_exc,
  output logic        bus_err
);
  localparam int          NUM_LANES = 4;
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Instruction held across the bus access so the MEM_WB side sees it in DONE.
  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  dst;
    logic [1:0]  wb;
    logic [1:0]  size;
    logic        uns;
    logic        ld;
  } op_t;

  state_t      state;
  op_t         q;
  logic [7:0]  cnt;
  logic [31:0] rd_q;

  logic        mem_op, misal;
  logic [1:0]  in_lane;
  logic        in_hlane;
  logic [NUM_LANES-1:0][7:0] st_bytes;
  logic [NUM_LANES-1:0]      st_be;

  logic [1:0]  ld_lane;
  logic        ld_hlane;
  logic [31:0] ld_data;

  assign mem_op   = MemRead | MemWrite;
  // Size 11 behaves as a word, so word alignment keys off size[1].
  assign misal    = ((mem_size == 2'b01) & ALUOutput_in[0]) |
                    (mem_size[1] & (ALUOutput_in[1:0] != 2'b00));
  assign in_lane  = BIG_ENDIAN ? (2'd3 - ALUOutput_in[1:0]) : ALUOutput_in[1:0];
  assign in_hlane = BIG_ENDIAN ? ~ALUOutput_in[1] : ALUOutput_in[1];
  assign ld_lane  = BIG_ENDIAN ? (2'd3 - q.alu[1:0]) : q.alu[1:0];
  assign ld_hlane = BIG_ENDIAN ? ~q.alu[1] : q.alu[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_lane #(.LANE(g)) u_lane (
      .size   (mem_size),
      .lane   (in_lane),
      .hlane  (in_hlane),
      .wd     (WriteData_in),
      .byte_d (st_bytes[g]),
      .be     (st_be[g])
    );
  end

  // Extract the addressed byte/half from the bus and extend it to 32 bits.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = dmem_rdata[{ld_lane, 3'b000} +: 8];
    h = dmem_rdata[{ld_hlane, 4'b0000} +: 16];
    case (q.size)
      2'b00:   ld_data = q.uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   ld_data = q.uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Access FSM: latch the op in IDLE, hold the bus in BUSY, present in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      cnt        <= '0;
      rd_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !misal) begin
            q          <= '{alu: ALUOutput_in, dst: DstReg_in, wb: WB_in,
                            size: mem_size, uns: mem_unsigned, ld: MemRead};
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= {ALUOutput_in[31:2], 2'b00};
            dmem_wdata <= st_bytes;
            dmem_be    <= MemWrite ? st_be : 4'b0000;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Ack takes priority over a coincident timeout.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (q.ld) rd_q <= ld_data;
            state    <= DONE;
          end else if (cnt == TO_LAST) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage outputs: pass-through in IDLE, bubble while busy, latched op in DONE.
  always_comb begin
    stall         = 1'b0;
    misalign_exc  = 1'b0;
    bus_err       = 1'b0;
    ReadData_out  = '0;
    ALUOutput_out = ALUOutput_in;
    DstReg_out    = DstReg_in;
    WB_out        = WB_in;
    case (state)
      IDLE: begin
        if (mem_op) begin
          WB_out       = 2'b00;
          stall        = !misal;
          misalign_exc = misal;
        end
      end
      BUSY: begin
        stall         = 1'b1;
        WB_out        = 2'b00;
        ALUOutput_out = q.alu;
        DstReg_out    = q.dst;
        bus_err       = !dmem_ack && (cnt == TO_LAST);
      end
      DONE: begin
        ReadData_out  = rd_q;
        ALUOutput_out = q.alu;
        DstReg_out    = q.dst;
        WB_out        = q.wb;
      end
      default: ;
    endcase
  end
endmodule
